// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional MUL_DIV_FAST_MUL_EN computes all multiplies in a single cycle at latch time.
module mul_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       func_q;
  logic [XLEN-1:0]  hi_q, lo_q, opnd_q, spec_val_q, result_q;
  logic             neg_q, spec_q, busy_q, done_q;

  logic             is_mul, sgn_a, sgn_b, neg_new, div0, ovf, spec_new;
  logic [XLEN-1:0]  mag_a, mag_b, spec_new_val;

  always_comb begin
    is_mul       = ~funct3[2];
    sgn_a        = op_a[XLEN-1] & (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
    sgn_b        = op_b[XLEN-1] & (funct3 inside {3'd1, 3'd4, 3'd6});
    mag_a        = sgn_a ? -op_a : op_a;
    mag_b        = sgn_b ? -op_b : op_b;
    // Remainder follows the dividend's sign; everything else uses the sign product.
    neg_new      = (is_mul || !funct3[1]) ? (sgn_a ^ sgn_b) : sgn_a;
    div0         = ~is_mul & (op_b == '0);
    ovf          = (funct3 inside {3'd4, 3'd6}) & (op_a == MinInt) & (op_b == '1);
    spec_new     = div0 | ovf;
    spec_new_val = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MinInt);
  end

`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  always_comb begin
    ext_a     = {{XLEN{sgn_a}}, op_a};
    ext_b     = {{XLEN{sgn_b}}, op_b};
    fast_prod = ext_a * ext_b;
  end
`endif

  // One iteration step; hi/lo hold partial product or remainder/quotient.
  logic [XLEN:0]   add_sum, shifted;
  logic [XLEN-1:0] diff, hi_step, lo_step;
  logic            ge;

  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted[XLEN-1:0] - opnd_q;
    ge      = shifted >= {1'b0, opnd_q};
    if (!func_q[2]) begin
      hi_step = add_sum[XLEN:1];
      lo_step = {add_sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_step = ge ? diff : shifted[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ge};
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    if (spec_q) begin
      final_res = spec_val_q;
    end else if (func_q == 3'd0) begin
      final_res = prod_s[XLEN-1:0];
    end else if (!func_q[2]) begin
      final_res = prod_s[2*XLEN-1:XLEN];
    end else if (!func_q[1]) begin
      final_res = neg_q ? -lo_q : lo_q;
    end else begin
      final_res = neg_q ? -hi_q : hi_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
`ifdef MUL_DIV_FAST_MUL_EN
          if (is_mul) state_d = StDone;
`endif
        end
      end
      StCalc:  if (cnt_q == '1) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      func_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      spec_val_q <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_d != StIdle);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            func_q     <= funct3;
            neg_q      <= neg_new;
            spec_q     <= spec_new;
            spec_val_q <= spec_new_val;
            cnt_q      <= '0;
            hi_q       <= '0;
            opnd_q     <= is_mul ? mag_a : mag_b;
            lo_q       <= is_mul ? mag_b : mag_a;
`ifdef MUL_DIV_FAST_MUL_EN
            if (is_mul) begin
              hi_q  <= fast_prod[2*XLEN-1:XLEN];
              lo_q  <= fast_prod[XLEN-1:0];
              neg_q <= 1'b0;
            end
`endif
          end
        end
        StCalc: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q + 1'b1;
        end
        StDone: begin
          result_q <= final_res;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int compared = 0;
  int mismatched = 0;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct3(funct3),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: r = sa * sb;
      3'd1: r = sa * sb;
      3'd2: r = sa * ub;
      3'd3: r = ua * ub;
      3'd4: r = (b == 0) ? -1 : (a == 32'h8000_0000 && b == '1) ? sa : sa / sb;
      3'd5: r = (b == 0) ? -1 : ua / ub;
      3'd6: r = (b == 0) ? sa : (a == 32'h8000_0000 && b == '1) ? 0 : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    p = r;
    return (f == 3'd1 || f == 3'd2 || f == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] f);
`ifdef MUL_DIV_FAST_MUL_EN
    return f[2] ? 33 : 1;
`else
    return (f[2] || !f[2]) ? 33 : 33;
`endif
  endfunction

  // Start one op and count edges from the accept edge until done is seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) $display("FAIL timeout: no done within 100 cycles for funct3=%0d", f);
    res = result;
  endtask

  initial begin
    logic [31:0] res, exp_b, held;
    logic [2:0]  f;
    logic [31:0] a, b;
    int          lat, seen;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5};
    vecs[10] = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[11] = '{3'd7, 32'd5,          32'd0,          32'd5};
    vecs[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].f)));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
      check($sformatf("vec%0d_held", i), result, vecs[i].exp);
    end

    // start pulses while busy must not disturb the running divide.
    @(negedge clk);
    funct3 = 3'd4;
    op_a   = 32'hFFFF_FC18;
    op_b   = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      funct3 = 3'($urandom_range(0, 7));
      op_a   = $urandom;
      op_b   = $urandom;
      start  = n[0];
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("ignored_start_result", result, ref_model(3'd4, 32'hFFFF_FC18, 32'd7));
    check("ignored_start_latency", 32'(lat), 32'd33);
    @(posedge clk);
    #1;
    check("ignored_start_idle", {31'b0, busy}, 32'd0);

    // start held high: the next op is accepted the edge after done.
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    funct3 = 3'd3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("b2b_first_result", result, ref_model(3'd3, a, b));
    check("b2b_first_latency", 32'(lat), 32'(exp_lat(3'd3)));
    funct3 = 3'd6;
    op_a   = $urandom;
    op_b   = 32'($urandom_range(1, 1000));
    exp_b  = ref_model(3'd6, op_a, op_b);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("b2b_second_result", result, exp_b);
    check("b2b_second_latency", 32'(lat), 32'd34);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(f, a, b, res, lat);
      check($sformatf("rand%0d_f%0d_a%h_b%h", i, f, a, b), res, ref_model(f, a, b));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(f)));
    end

    // Reset in the middle of a divide aborts it without a done pulse.
    held = result;
    @(negedge clk);
    funct3 = 3'd5;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, (held == 32'd0) ? held : 32'd0);
    reset = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
